// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module  : id_ex_stage
// Brief   : ID/EX pipeline register feeding the ALU. Performs capture-time
//           WB bypass, EX/MEM and MEM/WB operand forwarding, load-use stall
//           detection, bubble insertion and saturating stall/flush counters.
// Revision: 1.0 - initial release
// ============================================================================
module id_ex_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs_addr,
  input  logic [4:0]       id_rt_addr,
  input  logic [4:0]       id_rd_addr,
  input  logic [31:0]      id_rs_data,
  input  logic [31:0]      id_rt_data,
  input  logic [31:0]      id_imm,
  input  logic             id_use_imm,
  input  logic [3:0]       id_alu_control,
  input  logic [4:0]       id_shamt,
  input  logic [2:0]       id_branch_type,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             id_mem_write,
  input  logic             id_mem_to_reg,
  input  logic             flush,
  input  logic             exmem_reg_write,
  input  logic [4:0]       exmem_rd,
  input  logic [31:0]      exmem_result,
  input  logic             memwb_reg_write,
  input  logic [4:0]       memwb_rd,
  input  logic [31:0]      memwb_result,
  output logic             id_stall,
  output logic             ex_valid,
  output logic [31:0]      ex_A,
  output logic [31:0]      ex_B,
  output logic [31:0]      ex_store_data,
  output logic [3:0]       ex_alu_control,
  output logic [4:0]       ex_shamt,
  output logic [2:0]       ex_branch_type,
  output logic [4:0]       ex_rd,
  output logic             ex_reg_write,
  output logic             ex_mem_read,
  output logic             ex_mem_write,
  output logic             ex_mem_to_reg,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

  logic             valid_q;
  logic [3:0]       alu_q;
  logic [4:0]       shamt_q;
  logic [2:0]       br_q;
  logic [4:0]       rd_q;
  logic             rw_q, mr_q, mw_q, m2r_q;
  logic [4:0]       rs_addr_q, rt_addr_q;
  logic [31:0]      rs_data_q, rt_data_q, imm_q;
  logic             use_imm_q;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [31:0]      cap_rs, cap_rt;
  logic [31:0]      fwd_rs, fwd_rt;

  // Load-use hazard: the load in EX writes a register the decode slot reads.
  // rt is always compared, even for instructions that do not use it.
  always_comb begin
    id_stall = valid_q & mr_q & (rd_q != 5'd0) & id_valid &
               ((rd_q == id_rs_addr) | (rd_q == id_rt_addr)) & ~flush;
  end

  // Register file has no write-through, so bypass the writeback at capture.
  always_comb begin
    cap_rs = id_rs_data;
    cap_rt = id_rt_data;
    if (memwb_reg_write && (memwb_rd != 5'd0) && (memwb_rd == id_rs_addr))
      cap_rs = memwb_result;
    if (memwb_reg_write && (memwb_rd != 5'd0) && (memwb_rd == id_rt_addr))
      cap_rt = memwb_result;
  end

  // Pipeline register: flush and stall both load a bubble, else capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= 1'b0;
      alu_q     <= 4'd0;
      shamt_q   <= 5'd0;
      br_q      <= 3'd0;
      rd_q      <= 5'd0;
      rw_q      <= 1'b0;
      mr_q      <= 1'b0;
      mw_q      <= 1'b0;
      m2r_q     <= 1'b0;
      rs_addr_q <= 5'd0;
      rt_addr_q <= 5'd0;
      rs_data_q <= 32'd0;
      rt_data_q <= 32'd0;
      imm_q     <= 32'd0;
      use_imm_q <= 1'b0;
    end else if (flush || id_stall) begin
      valid_q <= 1'b0;
      alu_q   <= 4'd0;
      shamt_q <= 5'd0;
      br_q    <= 3'd0;
      rd_q    <= 5'd0;
      rw_q    <= 1'b0;
      mr_q    <= 1'b0;
      mw_q    <= 1'b0;
      m2r_q   <= 1'b0;
    end else begin
      valid_q   <= id_valid;
      alu_q     <= id_alu_control;
      shamt_q   <= id_shamt;
      br_q      <= id_branch_type;
      rd_q      <= id_rd_addr;
      rw_q      <= id_reg_write;
      mr_q      <= id_mem_read;
      mw_q      <= id_mem_write;
      m2r_q     <= id_mem_to_reg;
      rs_addr_q <= id_rs_addr;
      rt_addr_q <= id_rt_addr;
      rs_data_q <= cap_rs;
      rt_data_q <= cap_rt;
      imm_q     <= id_imm;
      use_imm_q <= id_use_imm;
    end
  end

  // Saturating counters: flush takes precedence, so only one moves per cycle.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (flush) begin
      if (flush_cnt_q != C_CNT_MAX) flush_cnt_d = flush_cnt_q + 1'b1;
    end else if (id_stall) begin
      if (stall_cnt_q != C_CNT_MAX) stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // EX forwarding: EX/MEM beats MEM/WB beats the latched operand; r0 never.
  always_comb begin
    fwd_rs = rs_data_q;
    fwd_rt = rt_data_q;
    if (exmem_reg_write && (exmem_rd != 5'd0) && (exmem_rd == rs_addr_q))
      fwd_rs = exmem_result;
    else if (memwb_reg_write && (memwb_rd != 5'd0) && (memwb_rd == rs_addr_q))
      fwd_rs = memwb_result;
    if (exmem_reg_write && (exmem_rd != 5'd0) && (exmem_rd == rt_addr_q))
      fwd_rt = exmem_result;
    else if (memwb_reg_write && (memwb_rd != 5'd0) && (memwb_rd == rt_addr_q))
      fwd_rt = memwb_result;
  end

  assign ex_A           = fwd_rs;
  assign ex_store_data  = fwd_rt;
  assign ex_B           = use_imm_q ? imm_q : fwd_rt;
  assign ex_valid       = valid_q;
  assign ex_alu_control = alu_q;
  assign ex_shamt       = shamt_q;
  assign ex_branch_type = br_q;
  assign ex_rd          = rd_q;
  assign ex_reg_write   = rw_q;
  assign ex_mem_read    = mr_q;
  assign ex_mem_write   = mw_q;
  assign ex_mem_to_reg  = m2r_q;
  assign stall_cnt      = stall_cnt_q;
  assign flush_cnt      = flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_id_ex_stage
// Brief   : Directed self-checking bench for id_ex_stage with a behavioural
//           model of the EX slot and a per-cycle compare process.
// Revision: 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;

  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic id_valid = 0, id_use_imm = 0, id_reg_write = 0, id_mem_read = 0;
  logic id_mem_write = 0, id_mem_to_reg = 0, flush = 0;
  logic [4:0] id_rs_addr = 0, id_rt_addr = 0, id_rd_addr = 0, id_shamt = 0;
  logic [31:0] id_rs_data = 0, id_rt_data = 0, id_imm = 0;
  logic [3:0] id_alu_control = 0;
  logic [2:0] id_branch_type = 0;
  logic exmem_reg_write = 0, memwb_reg_write = 0;
  logic [4:0] exmem_rd = 0, memwb_rd = 0;
  logic [31:0] exmem_result = 0, memwb_result = 0;

  logic id_stall, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
  logic [31:0] ex_A, ex_B, ex_store_data;
  logic [3:0] ex_alu_control;
  logic [4:0] ex_shamt, ex_rd;
  logic [2:0] ex_branch_type;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  id_ex_stage #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs_addr(id_rs_addr),
    .id_rt_addr(id_rt_addr), .id_rd_addr(id_rd_addr), .id_rs_data(id_rs_data),
    .id_rt_data(id_rt_data), .id_imm(id_imm), .id_use_imm(id_use_imm),
    .id_alu_control(id_alu_control), .id_shamt(id_shamt),
    .id_branch_type(id_branch_type), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_mem_to_reg(id_mem_to_reg), .flush(flush),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .id_stall(id_stall), .ex_valid(ex_valid), .ex_A(ex_A), .ex_B(ex_B),
    .ex_store_data(ex_store_data), .ex_alu_control(ex_alu_control),
    .ex_shamt(ex_shamt), .ex_branch_type(ex_branch_type), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model of the EX slot ----------------
  bit       m_valid, m_rw, m_mr, m_mw, m_m2r, m_ui;
  int       m_alu, m_shamt, m_br, m_rd, m_rsa, m_rta;
  int       m_sc, m_fc;
  bit [31:0] m_rsv, m_rtv, m_imm;

  function automatic bit model_stall();
    return m_valid && m_mr && m_rd != 0 && id_valid &&
           (m_rd == id_rs_addr || m_rd == id_rt_addr) && !flush;
  endfunction

  // Value a register read should see: newest pending write wins.
  function automatic bit [31:0] newest(input int addr, input bit [31:0] fallback,
                                       input bit use_exmem);
    if (addr == 0) return fallback;
    if (use_exmem && exmem_reg_write && exmem_rd == addr) return exmem_result;
    if (memwb_reg_write && memwb_rd == addr) return memwb_result;
    return fallback;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_m2r = 0; m_ui = 0;
      m_alu = 0; m_shamt = 0; m_br = 0; m_rd = 0; m_rsa = 0; m_rta = 0;
      m_sc = 0; m_fc = 0; m_rsv = 0; m_rtv = 0; m_imm = 0;
    end else if (flush || model_stall()) begin
      if (flush) m_fc = (m_fc < CMAX) ? m_fc + 1 : CMAX;
      else       m_sc = (m_sc < CMAX) ? m_sc + 1 : CMAX;
      m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_m2r = 0;
      m_alu = 0; m_shamt = 0; m_br = 0; m_rd = 0;
    end else begin
      m_rsv = newest(id_rs_addr, id_rs_data, 1'b0);
      m_rtv = newest(id_rt_addr, id_rt_data, 1'b0);
      m_valid = id_valid; m_rw = id_reg_write; m_mr = id_mem_read;
      m_mw = id_mem_write; m_m2r = id_mem_to_reg; m_ui = id_use_imm;
      m_alu = id_alu_control; m_shamt = id_shamt; m_br = id_branch_type;
      m_rd = id_rd_addr; m_rsa = id_rs_addr; m_rta = id_rt_addr; m_imm = id_imm;
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    bit [31:0] a, st;
    a  = newest(m_rsa, m_rsv, 1'b1);
    st = newest(m_rta, m_rtv, 1'b1);
    check("id_stall", id_stall, model_stall());
    check("ex_valid", ex_valid, m_valid);
    check("ex_ctrl", {ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg},
          {m_rw, m_mr, m_mw, m_m2r});
    check("ex_alu_control", ex_alu_control, m_alu);
    check("ex_shamt", ex_shamt, m_shamt);
    check("ex_branch_type", ex_branch_type, m_br);
    check("ex_rd", ex_rd, m_rd);
    check("stall_cnt", stall_cnt, m_sc);
    check("flush_cnt", flush_cnt, m_fc);
    if (m_valid) begin
      check("ex_A", ex_A, a);
      check("ex_store_data", ex_store_data, st);
      check("ex_B", ex_B, m_ui ? m_imm : st);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle_wb();
    exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
    memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
  endtask

  task automatic decode(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [31:0] rsd,
                        input logic [31:0] rtd, input logic mr, input logic rw);
    id_valid = v; id_rs_addr = rs; id_rt_addr = rt; id_rd_addr = rd;
    id_rs_data = rsd; id_rt_data = rtd; id_mem_read = mr; id_reg_write = rw;
    id_mem_to_reg = mr; id_mem_write = 0; id_use_imm = 0; id_imm = 0;
    id_alu_control = 4'h2; id_shamt = 5'd3; id_branch_type = 3'b000;
  endtask

  initial begin
    #12 rst = 0;
    tick();
    // capture something non-trivial, then reset mid-cycle
    decode(1, 5'd1, 5'd2, 5'd9, 32'h11, 32'h22, 0, 1);
    id_branch_type = 3'b010;
    tick();
    check("pre_reset_valid", ex_valid, 1'b1);
    #3 rst = 1; #1;
    check("rst_ex_valid", ex_valid, 1'b0);
    check("rst_branch", ex_branch_type, 3'b000);
    check("rst_ctrl", {ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg}, 4'b0);
    check("rst_counters", {stall_cnt, flush_cnt}, 8'h00);
    check("rst_A", ex_A, 32'h0);
    check("rst_B", ex_B, 32'h0);
    tick(); rst = 0;

    // Forwarding priority: latched rs = 3
    decode(1, 5'd3, 5'd4, 5'd6, 32'h33, 32'h44, 0, 1);
    tick();
    idle_wb();
    exmem_reg_write = 1; exmem_rd = 3; exmem_result = 32'h10;
    memwb_reg_write = 1; memwb_rd = 3; memwb_result = 32'h20;
    decode(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
    #1 check("fwd_exmem", ex_A, 32'h10);
    exmem_rd = 0; #1 check("fwd_memwb", ex_A, 32'h20);
    exmem_reg_write = 0; memwb_reg_write = 0; #1 check("fwd_none", ex_A, 32'h33);
    idle_wb();

    // Capture-time WB bypass of rt
    memwb_reg_write = 1; memwb_rd = 8; memwb_result = 32'hBEEF;
    decode(1, 5'd7, 5'd8, 5'd9, 32'h70, 32'h80, 0, 1);
    tick(); idle_wb();
    #1 check("cap_bypass_rt", ex_store_data, 32'hBEEF);

    // Load-use: lw r5, then add using rs = 5
    decode(1, 5'd1, 5'd2, 5'd5, 32'h1, 32'h2, 1, 1);
    tick();
    decode(1, 5'd5, 5'd6, 5'd7, 32'h0, 32'h66, 0, 1);
    #1 check("lu_stall", id_stall, 1'b1);
    tick();
    check("lu_bubble_valid", ex_valid, 1'b0);
    check("lu_bubble_br", ex_branch_type, 3'b000);
    check("lu_stall_cnt", stall_cnt, 4'd1);
    check("lu_stall_clear", id_stall, 1'b0);
    exmem_reg_write = 1; exmem_rd = 5; exmem_result = 32'h0;
    tick(); idle_wb();
    memwb_reg_write = 1; memwb_rd = 5; memwb_result = 32'hABCD;
    #1 check("lu_memwb_fwd", ex_A, 32'hABCD);
    idle_wb();

    // Flush concurrent with load-use
    decode(1, 5'd1, 5'd2, 5'd5, 32'h1, 32'h2, 1, 1);
    tick();
    decode(1, 5'd5, 5'd6, 5'd7, 32'h0, 32'h66, 0, 1);
    flush = 1;
    #1 check("flush_no_stall", id_stall, 1'b0);
    tick(); flush = 0;
    check("flush_bubble", ex_valid, 1'b0);
    check("flush_cnt", flush_cnt, 4'd1);
    check("flush_stall_cnt", stall_cnt, 4'd1);

    // Immediate B with rt forwarding
    decode(1, 5'd2, 5'd7, 5'd8, 32'h2, 32'h7, 0, 1);
    id_use_imm = 1; id_imm = 32'hFFFFFFFC;
    tick();
    exmem_reg_write = 1; exmem_rd = 7; exmem_result = 32'h77;
    decode(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
    #1 check("imm_B", ex_B, 32'hFFFFFFFC);
    check("imm_store", ex_store_data, 32'h77);
    tick(); idle_wb();

    // Repeated lw r5,0(r5): stalls every other cycle until the counter sticks
    decode(1, 5'd5, 5'd0, 5'd5, 32'h0, 32'h0, 1, 1);
    for (int i = 0; i < 46; i++) tick();
    check("stall_sat", stall_cnt, 4'hF);

    // Reset mid-stall drops id_stall at once
    #1 if (!id_stall) tick();
    #1 check("pre_rst_stall", id_stall, 1'b1);
    #1 rst = 1; #1;
    check("rst_drop_stall", id_stall, 1'b0);
    check("rst_stall_cnt", stall_cnt, 4'h0);
    tick(); rst = 0; decode(0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
ID/EX pipeline boundary that directly feeds the ALU. It registers decoded operands and controls, and drives the ALU inputs (A, B, ALUControl, ShiftAmount, branch_type). It also performs EX/MEM and MEM/WB operand forwarding, detects load-use hazards, inserts bubbles, and keeps saturating stall and flush counters.

Parameters:
CNT_W, 16, width of the stall_cnt and flush_cnt performance counters

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
id_valid  in  1  decode slot holds a real instruction
id_rs_addr  in  5  source register rs
id_rt_addr  in  5  source register rt
id_rd_addr  in  5  destination register (already muxed rt/rd)
id_rs_data  in  32  register file read of rs
id_rt_data  in  32  register file read of rt
id_imm  in  32  extended immediate
id_use_imm  in  1  B operand = immediate
id_alu_control  in  4  ALU opcode
id_shamt  in  5  shift amount
id_branch_type  in  3  branch type (000 none, 001..110)
id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  in  1 each  decoded controls
flush  in  1  branch taken or redirect resolved in EX
exmem_reg_write  in  1, exmem_rd  in  5, exmem_result  in  32  EX/MEM writeback info
memwb_reg_write  in  1, memwb_rd  in  5, memwb_result  in  32  MEM/WB writeback info
id_stall  out  1  hold PC and IF/ID (combinational)
ex_valid  out  1  EX slot valid
ex_A  out  32  ALU A (forwarded)
ex_B  out  32  ALU B (immediate or forwarded rt)
ex_store_data  out  32  forwarded rt for stores
ex_alu_control  out  4, ex_shamt  out  5, ex_branch_type  out  3, ex_rd  out  5  registered decode fields
ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  out  1 each  registered controls
stall_cnt  out  CNT_W  saturating count of stall cycles
flush_cnt  out  CNT_W  saturating count of flush cycles

Behaviour:
- Reset (async, active-high): all registered state goes to 0, including ex_valid, all ex_* controls and fields, the latched rs/rt/imm/use_imm, and both counters. ex_A, ex_B and ex_store_data therefore read 0 while no forwarding match exists (rd 0 never matches).
- Load-use hazard: id_stall = ex_valid & ex_mem_read & (ex_rd != 0) & id_valid & (ex_rd == id_rs_addr | ex_rd == id_rt_addr) & !flush. The rt comparison is always made (conservative).
- Each rising edge, one of three cases applies, in priority order:
  1. flush = 1: load a bubble. ex_valid = 0; all controls 0; alu_control 0000; branch_type 000 (ALU Zero = 0); shamt 0; rd 0. flush_cnt increments.
  2. Else id_stall = 1: load the same bubble. stall_cnt increments. Upstream holds, so the stalled instruction is presented again next cycle.
  3. Else: capture all id_* fields; ex_valid <= id_valid.
- Capture-time WB bypass: when capturing, if memwb_reg_write & memwb_rd != 0 & memwb_rd == id_rs_addr, latch memwb_result as the rs operand instead of id_rs_data. The same rule applies to rt. The register file has no write-through.
- EX forwarding (combinational, from the latched rs/rt addresses), priority EX/MEM > MEM/WB > latched value:
  - Register 0 is never forwarded.
  - A match requires the corresponding *_reg_write = 1.
- Operand outputs:
  - ex_A = forwarded rs.
  - ex_store_data = forwarded rt.
  - ex_B = latched use_imm ? latched imm : forwarded rt.
- Latency: one cycle from decode capture to ALU inputs. Forwarding adds zero cycles.
- Counters saturate at all-ones and never wrap.
- Reset mid-stall or mid-flush: state clears immediately; id_stall drops as soon as ex_valid is 0.
- flush and load-use in the same cycle: flush wins; id_stall = 0 so fetch can redirect.

Test Plan:
1. Reset asserted asynchronously mid-cycle -> ex_valid, all ex_* controls and both counters read 0 immediately; ex_A = ex_B = 0 while exmem/memwb are idle.
2. add r3 in EX/MEM (exmem_result = 0x10), memwb also writing r3 = 0x20, latched rs = 3 -> ex_A = 0x10. Change exmem_rd to r0 -> ex_A = 0x20.
3. lw r5 in EX, next decode uses rs = 5 -> id_stall = 1 for one cycle; bubble with ex_branch_type = 000 and ex_valid = 0; stall_cnt = 1. The following cycle captures the instruction, with ex_A taken from the MEM/WB forward.
4. flush = 1 concurrent with a load-use condition -> id_stall = 0, bubble loaded, flush_cnt = 1, stall_cnt unchanged.
5. id_use_imm = 1, imm = 0xFFFFFFFC, rt forwarding active -> ex_B = 0xFFFFFFFC and ex_store_data = forwarded rt value.
6. Hold stall for 2^CNT_W + 5 cycles (CNT_W = 4) -> stall_cnt sticks at 0xF.
